// File: rtl/hs_req_ack_tx_pkg.sv
// Shared types and defaults for the 4-phase req/ack transmit controller.
package hs_req_ack_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_req_ack_tx_if.sv
// Local valid/ready word input and the cross-domain req/data/ack bundle.
interface hs_req_ack_tx_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             x_req;
    logic [WIDTH-1:0] x_data;
    logic             x_ack_async;

    // master is the transmit controller, slave is the surrounding logic
    modport master (
        input  s_valid, s_data, x_ack_async,
        output s_ready, x_req, x_data
    );

    modport slave (
        output s_valid, s_data, x_ack_async,
        input  s_ready, x_req, x_data
    );
endinterface

// File: rtl/ff_synchronizer.sv
// Plain flop-chain synchronizer for a single asynchronous bit.
module ff_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/hs_req_ack_tx.sv
// Source side of a 4-phase req/ack crossing: holds one word on x_data per handshake,
// watches the synchronized ack, counts transfers and flags stalled handshakes.
module hs_req_ack_tx
    import hs_req_ack_tx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hs_req_ack_tx_if.master      bus,
    input  logic                 err_clr,
    output logic                 done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     xfer_cnt
);
    localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC > 0);

    hs_state_t        state, state_next;
    logic             ack_s;
    logic             accept;
    logic             wait_state;
    logic             state_change;
    logic             timeout_hit;
    logic             handshake_done;
    logic             x_req_q;
    logic [WIDTH-1:0] x_data_q;
    logic [WAIT_W-1:0] wait_cnt;

    // The synchronizer has no reset so a stale remote ack stays visible across our reset
    ff_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (1'b1),
        .d     (bus.x_ack_async),
        .q     (ack_s)
    );

    assign bus.s_ready  = (state == IDLE) && !ack_s;
    assign accept       = bus.s_valid && bus.s_ready;
    assign busy         = (state != IDLE);
    assign wait_state   = (state == REQ) || (state == REL);
    assign state_change = (state_next != state);
    assign timeout_hit  = TIMEOUT_EN && wait_state && (wait_cnt == WAIT_LAST);
    assign bus.x_req    = x_req_q;
    assign bus.x_data   = x_data_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        handshake_done = 1'b0;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ:  if (ack_s)  state_next = REL;
            REL:  if (!ack_s) begin
                      state_next     = IDLE;
                      handshake_done = 1'b1;
                  end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_req_q  <= 1'b0;
            x_data_q <= '0;
            done     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            x_req_q <= (state_next == REQ);
            if (accept) x_data_q <= bus.s_data;
            done <= handshake_done;
            if (handshake_done) xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    // Set fires only on the step into saturation, so a cleared flag stays clear while parked
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_change || !wait_state)
                wait_cnt <= '0;
            else if (TIMEOUT_EN && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;

            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hs_req_ack_tx.sv
// Directed bench for hs_req_ack_tx with a remote model echoing req to ack after 3 cycles.
module tb_hs_req_ack_tx;
    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 2;

    typedef struct {
        logic             rst_before;
        logic [WIDTH-1:0] data;
        logic             hold;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_clr = 1'b0;
    logic             done;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] xfer_cnt;

    logic             use_echo = 1'b1;
    logic             ack_force = 1'b0;
    logic [2:0]       req_dly = '0;

    int               compared = 0;
    int               mismatched = 0;
    int               done_seen = 0;
    int               unstable_events = 0;
    logic             prev_busy = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    vec_t             vecs [9];

    hs_req_ack_tx_if #(.WIDTH(WIDTH)) bus ();

    hs_req_ack_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .done        (done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Remote side: ack follows req three clocks later unless overridden
    always @(posedge clk) req_dly <= {req_dly[1:0], bus.x_req};
    assign bus.x_ack_async = use_echo ? req_dly[2] : ack_force;

    always @(negedge clk) begin
        if (!rst && done) done_seen <= done_seen + 1;
        if (!rst && prev_busy && busy && (bus.x_data !== prev_data))
            unstable_events <= unstable_events + 1;
        prev_busy <= busy;
        prev_data <= bus.x_data;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " x_req"},   bus.x_req,   0);
        check_output({name, " x_data"},  bus.x_data,  0);
        check_output({name, " done"},    done,        0);
        check_output({name, " busy"},    busy,        0);
        check_output({name, " err"},     err_timeout, 0);
        check_output({name, " cnt"},     xfer_cnt,    0);
        check_output({name, " s_ready"}, bus.s_ready, 1);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while ((bus.s_ready !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check_output({name, " s_ready"}, bus.s_ready, 1);
    endtask

    task automatic wait_done(input string name, input logic [WIDTH-1:0] data);
        bit stable = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if ((bus.x_data !== data) || (bus.s_ready !== 1'b0) || (busy !== 1'b1))
                stable = 1'b0;
        end
        check_output({name, " done"},   done,   1);
        check_output({name, " stable"}, stable, 1);
        check_output({name, " x_req_low"}, bus.x_req, 0);
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        bus.s_data  = v.data;
        bus.s_valid = 1'b1;
        wait_ready(name);
        @(negedge clk);
        if (!v.hold) bus.s_valid = 1'b0;
        bus.s_data = ~v.data;
        check_output({name, " x_req"},  bus.x_req,   1);
        check_output({name, " x_data"}, bus.x_data,  v.data);
        check_output({name, " busy"},   busy,        1);
        wait_done(name, v.data);
        check_output({name, " cnt"}, xfer_cnt, v.exp_cnt);
    endtask

    initial begin
        bit ok;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // basic, back-to-back, then counter wrap with CNT_W=2
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 2'd1};
        vecs[1] = '{1'b1, 8'h01, 1'b1, 2'd1};
        vecs[2] = '{1'b0, 8'h02, 1'b1, 2'd2};
        vecs[3] = '{1'b0, 8'h03, 1'b0, 2'd3};
        vecs[4] = '{1'b1, 8'h10, 1'b0, 2'd1};
        vecs[5] = '{1'b0, 8'h11, 1'b0, 2'd2};
        vecs[6] = '{1'b0, 8'h12, 1'b0, 2'd3};
        vecs[7] = '{1'b0, 8'h13, 1'b0, 2'd0};
        vecs[8] = '{1'b0, 8'h14, 1'b0, 2'd1};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst_before) begin
                bus.s_valid = 1'b0;
                apply_reset(3);
                check_reset_state($sformatf("vec%0d reset", i));
            end
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end
        bus.s_valid = 1'b0;

        $display("[TB] stale ack after reset");
        use_echo  = 1'b0;
        ack_force = 1'b1;
        apply_reset(3);
        bus.s_data  = 8'h5A;
        bus.s_valid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if ((bus.s_ready !== 1'b0) || (bus.x_req !== 1'b0)) ok = 1'b0;
        end
        check_output("stale blocked", ok, 1);
        ack_force = 1'b0;
        @(negedge clk);
        check_output("stale ready d1", bus.s_ready, 0);
        @(negedge clk);
        check_output("stale ready d2", bus.s_ready, 1);
        check_output("stale x_req d2", bus.x_req, 0);
        @(negedge clk);
        check_output("stale x_req d3", bus.x_req, 1);
        check_output("stale x_data", bus.x_data, 8'h5A);
        bus.s_valid = 1'b0;
        use_echo    = 1'b1;
        wait_done("stale", 8'h5A);
        check_output("stale cnt", xfer_cnt, 1);

        $display("[TB] timeout with silent remote");
        use_echo  = 1'b0;
        ack_force = 1'b0;
        apply_reset(3);
        bus.s_data  = 8'hC3;
        bus.s_valid = 1'b1;
        check_output("to s_ready", bus.s_ready, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check_output("to x_req", bus.x_req, 1);
        ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (err_timeout !== 1'b0) ok = 1'b0;
        end
        check_output("to not early", ok, 1);
        @(negedge clk);
        check_output("to err set", err_timeout, 1);
        check_output("to x_req held", bus.x_req, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("to err cleared", err_timeout, 0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if ((err_timeout !== 1'b0) || (bus.x_req !== 1'b1)) ok = 1'b0;
        end
        check_output("to stays clear", ok, 1);
        use_echo = 1'b1;
        wait_done("to late", 8'hC3);
        check_output("to cnt", xfer_cnt, 1);
        check_output("to err after", err_timeout, 0);

        $display("[TB] reset during REQ with ack high");
        use_echo = 1'b1;
        apply_reset(3);
        bus.s_data  = 8'h77;
        bus.s_valid = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check_output("mid x_req", bus.x_req, 1);
        for (int n = 0; n < 20; n++) begin
            if (bus.x_ack_async === 1'b1) break;
            @(negedge clk);
        end
        check_output("mid ack seen", bus.x_ack_async, 1);
        ack_force = 1'b1;
        use_echo  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid x_req after rst", bus.x_req, 0);
        check_output("mid busy after rst", busy, 0);
        check_output("mid cnt after rst", xfer_cnt, 0);
        check_output("mid s_ready after rst", bus.s_ready, 0);
        bus.s_data  = 8'h88;
        bus.s_valid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ((bus.s_ready !== 1'b0) || (bus.x_req !== 1'b0)) ok = 1'b0;
        end
        check_output("mid blocked", ok, 1);
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        check_output("mid ready", bus.s_ready, 1);
        @(negedge clk);
        check_output("mid x_req new", bus.x_req, 1);
        check_output("mid x_data new", bus.x_data, 8'h88);
        bus.s_valid = 1'b0;
        use_echo    = 1'b1;
        wait_done("mid", 8'h88);
        check_output("mid cnt", xfer_cnt, 1);

        repeat (2) @(negedge clk);
        #1;
        check_output("done pulses total", done_seen, 12);
        check_output("x_data held while busy", unstable_events, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
